// File: rtl/muu_pkg.sv
// Shared definitions for the MUU response path: arbiter states and limits.
package muu_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_e;

    // Largest value the per-packet beat counter can show; it sticks there.
    localparam int unsigned MAX_PKT_BEATS = 1023;
    localparam int unsigned PKT_CNT_W     = 10;

    // Width of a port index; covers up to 8 requesters.
    localparam int unsigned IDX_W = 3;

endpackage

// File: rtl/muu_rr_pick.sv
// Round-robin first-valid selector: scans req from ptr upward, wrapping.
module muu_rr_pick
    import muu_pkg::*;
#(
    parameter int NUM_PORTS = 4
) (
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic [IDX_W-1:0]     ptr_i,
    output logic [IDX_W-1:0]     idx_o,
    output logic                 any_o
);

    localparam logic [IDX_W:0] NP_W = NUM_PORTS[IDX_W:0];

    logic [2*NUM_PORTS-1:0] req_dbl;
    logic [NUM_PORTS-1:0]   req_rot;
    logic [IDX_W-1:0]       offset;
    logic [IDX_W:0]         sum;

    // Rotate requests so ptr sits at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned and infers a latch.
        offset  = '0;
        any_o   = 1'b0;
        req_dbl = {req_i, req_i};
        req_rot = NUM_PORTS'(req_dbl >> ptr_i);
        for (int i = NUM_PORTS - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                offset = IDX_W'(i);
                any_o  = 1'b1;
            end
        end
        // ptr and offset are both below NUM_PORTS, so one subtract wraps.
        sum = {1'b0, ptr_i} + {1'b0, offset};
        if (sum >= NP_W) begin
            sum = sum - NP_W;
        end
        idx_o = sum[IDX_W-1:0];
    end

endmodule

// File: rtl/muu_resp_arbiter.sv
// Packet-locked round-robin merge of NUM_PORTS response streams into one
// registered output stream with a one-cycle arbitration bubble per packet.
module muu_resp_arbiter
    import muu_pkg::*;
#(
    parameter int NUM_PORTS  = 4,
    parameter int DATA_WIDTH = 160,
    parameter int USER_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  in_data,
    input  logic [NUM_PORTS*USER_WIDTH-1:0]  in_user,
    input  logic [NUM_PORTS-1:0]             in_valid,
    input  logic [NUM_PORTS-1:0]             in_last,
    output logic [NUM_PORTS-1:0]             in_ready,
    output logic [DATA_WIDTH-1:0]            out_data,
    output logic [USER_WIDTH-1:0]            out_user,
    output logic                             out_valid,
    output logic                             out_last,
    input  logic                             out_ready,
    input  logic                             hold,
    output logic [IDX_W-1:0]                 grant_idx,
    output logic                             busy,
    output logic [PKT_CNT_W-1:0]             pkt_beats
);

    localparam int                   LAST_PORT = NUM_PORTS - 1;
    localparam logic [IDX_W-1:0]     LAST_IDX  = LAST_PORT[IDX_W-1:0];
    localparam logic [PKT_CNT_W-1:0] PKT_MAX   = MAX_PKT_BEATS[PKT_CNT_W-1:0];

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]     grant_q, grant_d;
    logic                 started_q;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic [USER_WIDTH-1:0] out_user_q;
    logic                 out_valid_q;
    logic                 out_last_q;
    logic [PKT_CNT_W-1:0] pkt_q;

    logic [DATA_WIDTH-1:0] sel_data;
    logic [USER_WIDTH-1:0] sel_user;
    logic                 sel_valid;
    logic                 sel_last;
    logic                 drain_ok;
    logic                 accept;
    logic                 grant_start;
    logic [IDX_W-1:0]     pick_idx;
    logic                 pick_any;

    muu_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_pick (
        .req_i (in_valid),
        .ptr_i (rr_ptr_q),
        .idx_o (pick_idx),
        .any_o (pick_any)
    );

    // Steer the granted port's beat onto the internal select bus.
    always_comb begin
        sel_data  = '0;
        sel_user  = '0;
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (grant_q == IDX_W'(i)) begin
                sel_data  = in_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_user  = in_user[i*USER_WIDTH +: USER_WIDTH];
                sel_valid = in_valid[i];
                sel_last  = in_last[i];
            end
        end
    end

    // The output register can take a beat when empty or draining this cycle.
    assign drain_ok    = !out_valid_q || out_ready;
    assign accept      = (state_q == ST_LOCKED) && sel_valid && drain_ok;
    assign grant_start = (state_q == ST_IDLE) && started_q && !hold && pick_any;

    // Only the granted port sees ready, and only while locked.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if ((state_q == ST_LOCKED) && (grant_q == IDX_W'(i))) begin
                in_ready[i] = drain_ok;
            end
        end
    end

    // Next state: grant from idle, release on the accepted last beat.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (grant_start) begin
                    state_d = ST_LOCKED;
                    grant_d = pick_idx;
                end
            end
            ST_LOCKED: begin
                if (accept && sel_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = (grant_q == LAST_IDX) ? '0 : grant_q + IDX_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Control registers; started_q blocks a grant in the first cycle after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            rr_ptr_q  <= '0;
            grant_q   <= '0;
            started_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            state_q   <= state_d;
            rr_ptr_q  <= rr_ptr_d;
            grant_q   <= grant_d;
            started_q <= 1'b1;
        end
    end

    // Output stage: load on accept, clear valid when drained with nothing new.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data path is reset too so no stale beat is visible after a mid-packet reset.
            out_data_q  <= '0;
            out_user_q  <= '0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else if (accept) begin
            out_data_q  <= sel_data;
            out_user_q  <= sel_user;
            out_valid_q <= 1'b1;
            out_last_q  <= sel_last;
        end else if (out_ready) begin
            out_valid_q <= 1'b0;
        end
    end

    // Beat counter for the current packet, sticking at its maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_q <= '0;
        end else if (grant_start) begin
            pkt_q <= '0;
        end else if (accept && (pkt_q != PKT_MAX)) begin
            pkt_q <= pkt_q + PKT_CNT_W'(1);
        end
    end

    assign out_data  = out_data_q;
    assign out_user  = out_user_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;
    assign grant_idx = grant_q;
    assign busy      = (state_q == ST_LOCKED);
    assign pkt_beats = pkt_q;

endmodule

// File: tb/tb_muu_resp_arbiter.sv
// Scoreboard bench: a packet-level round-robin model orders the expected
// beats; a monitor pops and compares whenever the output handshakes.
module tb_muu_resp_arbiter;

    localparam int NP = 4;
    localparam int DW = 160;
    localparam int UW = 8;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
    } beat_t;

    logic              clk;
    logic              rst_n;
    logic [NP*DW-1:0]  in_data;
    logic [NP*UW-1:0]  in_user;
    logic [NP-1:0]     in_valid;
    logic [NP-1:0]     in_last;
    logic [NP-1:0]     in_ready;
    logic [DW-1:0]     out_data;
    logic [UW-1:0]     out_user;
    logic              out_valid;
    logic              out_last;
    logic              out_ready;
    logic              hold;
    logic [2:0]        grant_idx;
    logic              busy;
    logic [9:0]        pkt_beats;

    muu_resp_arbiter #(
        .NUM_PORTS  (NP),
        .DATA_WIDTH (DW),
        .USER_WIDTH (UW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_user   (in_user),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_user  (out_user),
        .out_valid (out_valid),
        .out_last  (out_last),
        .out_ready (out_ready),
        .hold      (hold),
        .grant_idx (grant_idx),
        .busy      (busy),
        .pkt_beats (pkt_beats)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int    n_checks = 0;
    int    n_err    = 0;

    beat_t src_q[NP][$];
    beat_t exp_q[$];
    int    stage_len[NP][$];
    int    m_rr = 0;

    bit    mon_en    = 1'b0;
    bit    rdy_rand  = 1'b0;
    bit    hold_rand = 1'b0;
    bit    hold_force = 1'b0;
    int    stall_cnt = 0;
    int    beat_cnt  = 0;
    bit    pb_pending = 1'b0;
    int    pb_exp    = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_err++;
        $display("FAIL %s: condition not reached", name);
    endtask

    function automatic beat_t mk_beat(input bit last);
        beat_t b;
        b.data = {$urandom, $urandom, $urandom, $urandom, $urandom};
        b.user = UW'($urandom);
        b.last = last;
        return b;
    endfunction

    // Packet-level model: all staged packets are pending together, so the
    // service order is plain round robin over ports with a packet waiting.
    task automatic commit();
        bit found;
        int p;
        int len;
        beat_t b;
        forever begin
            found = 1'b0;
            p = 0;
            for (int k = 0; k < NP; k++) begin
                if (!found && stage_len[(m_rr + k) % NP].size() > 0) begin
                    found = 1'b1;
                    p = (m_rr + k) % NP;
                end
            end
            if (!found) break;
            len = stage_len[p].pop_front();
            for (int i = 0; i < len; i++) begin
                b = mk_beat(i == len - 1);
                src_q[p].push_back(b);
                exp_q.push_back(b);
            end
            m_rr = (p + 1) % NP;
        end
    endtask

    function automatic bit sources_empty();
        bit e = 1'b1;
        for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic drain(input string name);
        int n = 0;
        while (!(exp_q.size() == 0 && sources_empty() && !busy && !out_valid) && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20000) fail_now(name);
        repeat (3) @(negedge clk);
    endtask

    // Source driver: present queue heads, sample handshakes just before the edge.
    initial begin
        logic [NP-1:0] fire;
        beat_t b;
        in_data   = '0;
        in_user   = '0;
        in_valid  = '0;
        in_last   = '0;
        out_ready = 1'b1;
        hold      = 1'b0;
        forever begin
            @(negedge clk);
            if (pb_pending) begin
                check("pkt_beats_at_end", DW'(pkt_beats), DW'(pb_exp));
                check("busy_after_last", DW'(busy), DW'(0));
                pb_pending = 1'b0;
            end
            if (stall_cnt > 0) begin
                out_ready = 1'b0;
                stall_cnt--;
            end else if (rdy_rand) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            if (hold_force) hold = 1'b1;
            else if (hold_rand) hold = ($urandom_range(0, 7) == 0);
            else hold = 1'b0;
            for (int p = 0; p < NP; p++) begin
                if (src_q[p].size() > 0) begin
                    b = src_q[p][0];
                    in_valid[p] = 1'b1;
                    in_data[p*DW +: DW] = b.data;
                    in_user[p*UW +: UW] = b.user;
                    in_last[p] = b.last;
                end else begin
                    in_valid[p] = 1'b0;
                    in_data[p*DW +: DW] = '0;
                    in_user[p*UW +: UW] = '0;
                    in_last[p] = 1'b0;
                end
            end
            #4;
            fire = in_valid & in_ready;
            if (rst_n && ((fire & (fire - NP'(1))) != '0)) begin
                check("multi_port_accept", DW'(fire), DW'(0));
            end
            @(posedge clk);
            if (rst_n) begin
                for (int p = 0; p < NP; p++) begin
                    if (fire[p]) begin
                        b = src_q[p].pop_front();
                        beat_cnt++;
                        if (b.last) begin
                            pb_exp     = (beat_cnt > 1023) ? 1023 : beat_cnt;
                            pb_pending = 1'b1;
                            beat_cnt   = 0;
                        end
                    end
                end
            end
        end
    end

    // Monitor: compare each drained beat against the scoreboard, check stalls.
    initial begin
        bit    prev_stall = 1'b0;
        bit    prev_hold_idle = 1'b0;
        beat_t prev;
        beat_t e;
        prev = '0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst_n || !mon_en) begin
                prev_stall = 1'b0;
                prev_hold_idle = 1'b0;
                continue;
            end
            if (prev_stall) begin
                check("stall_valid_held", DW'(out_valid), DW'(1));
                check("stall_data_held", out_data, prev.data);
                check("stall_user_held", DW'(out_user), DW'(prev.user));
                check("stall_last_held", DW'(out_last), DW'(prev.last));
            end
            if (prev_hold_idle) check("no_grant_under_hold", DW'(busy), DW'(0));
            if (!busy) check("ready_zero_idle", DW'(in_ready), DW'(0));
            if (out_valid && !out_ready) check("ready_zero_stall", DW'(in_ready), DW'(0));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_beat");
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", out_data, e.data);
                    check("out_user", DW'(out_user), DW'(e.user));
                    check("out_last", DW'(out_last), DW'(e.last));
                end
            end
            prev_stall     = out_valid && !out_ready;
            prev_hold_idle = hold && !busy;
            prev.data = out_data;
            prev.user = out_user;
            prev.last = out_last;
        end
    end

    initial begin
        int n;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_out_valid", DW'(out_valid), DW'(0));
        check("rst_out_last", DW'(out_last), DW'(0));
        check("rst_out_data", out_data, DW'(0));
        check("rst_out_user", DW'(out_user), DW'(0));
        check("rst_in_ready", DW'(in_ready), DW'(0));
        check("rst_busy", DW'(busy), DW'(0));
        check("rst_grant_idx", DW'(grant_idx), DW'(0));
        check("rst_pkt_beats", DW'(pkt_beats), DW'(0));
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);

        // Two 3-beat packets on ports 0 and 2 at once.
        #2;
        stage_len[0].push_back(3);
        stage_len[2].push_back(3);
        commit();
        drain("drain_two_ports");
        check("grant_after_two_ports", DW'(grant_idx), DW'(2));

        // All ports offering single-beat packets back to back.
        @(negedge clk);
        #2;
        for (int p = 0; p < NP; p++) begin
            stage_len[p].push_back(1);
            stage_len[p].push_back(1);
        end
        commit();
        drain("drain_single_beats");

        // Five-cycle downstream stall in the middle of a packet.
        @(negedge clk);
        #2;
        stage_len[1].push_back(6);
        commit();
        repeat (3) @(negedge clk);
        stall_cnt = 5;
        drain("drain_stall");

        // Hold raised during a port 1 packet while port 3 waits.
        @(negedge clk);
        #2;
        stage_len[1].push_back(4);
        commit();
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("hold_port1_grant");
        hold_force = 1'b1;
        #2;
        stage_len[3].push_back(2);
        commit();
        repeat (20) @(negedge clk);
        check("hold_no_grant_busy", DW'(busy), DW'(0));
        check("hold_last_grant", DW'(grant_idx), DW'(1));
        hold_force = 1'b0;
        drain("drain_hold");

        // Randomized traffic with random backpressure and hold.
        rdy_rand  = 1'b1;
        hold_rand = 1'b1;
        for (int s = 0; s < 25; s++) begin
            @(negedge clk);
            #2;
            n = 0;
            for (int p = 0; p < NP; p++) begin
                for (int k = $urandom_range(0, 2); k > 0; k--) begin
                    stage_len[p].push_back($urandom_range(1, 6));
                    n++;
                end
            end
            if (n == 0) stage_len[$urandom_range(0, NP - 1)].push_back($urandom_range(1, 6));
            commit();
            drain("drain_random");
        end
        hold_rand = 1'b0;

        // Long packet: counter saturates, every beat still forwarded.
        @(negedge clk);
        #2;
        stage_len[0].push_back(1100);
        commit();
        drain("drain_long");
        rdy_rand = 1'b0;

        // Reset on beat 2 of a 4-beat packet, outside the scoreboard.
        mon_en = 1'b0;
        @(negedge clk);
        #2;
        for (int i = 0; i < 4; i++) src_q[1].push_back(mk_beat(i == 3));
        n = 0;
        while (beat_cnt < 2 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("reset_beat2_reached");
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", DW'(out_valid), DW'(0));
        check("midrst_in_ready", DW'(in_ready), DW'(0));
        check("midrst_busy", DW'(busy), DW'(0));
        check("midrst_pkt_beats", DW'(pkt_beats), DW'(0));
        for (int p = 0; p < NP; p++) src_q[p].delete();
        exp_q.delete();
        beat_cnt   = 0;
        pb_pending = 1'b0;
        m_rr       = 0;
        stage_len[3].push_back(2);
        stage_len[2].push_back(3);
        commit();
        @(negedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        @(negedge clk);
        check("no_grant_first_cycle", DW'(busy), DW'(0));
        @(negedge clk);
        check("post_reset_grant_busy", DW'(busy), DW'(1));
        check("post_reset_grant_idx", DW'(grant_idx), DW'(2));
        drain("drain_after_reset");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
